// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_t    : IDLE / ACCESS / RESP request-sequencing states
//   BYTE_W, LANES  : byte width and number of byte lanes per data word
//   replicate_byte : copies one byte onto every lane of a data word
package lsu_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    function automatic logic [BYTE_W*LANES-1:0] replicate_byte(input logic [BYTE_W-1:0] b);
        return {LANES{b}};
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: combinational load-data alignment and extension.
//   rd        : word-aligned read data from memory
//   offset    : byte offset within the word (address bits [1:0])
//   byte_mode : 1 = byte load, 0 = word load (pass rd through)
//   sext      : byte load only, 1 = sign-extend, 0 = zero-extend
//   result    : extended load result
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  offset,
    input  logic        byte_mode,
    input  logic        sext,
    output logic [31:0] result
);

    logic [BYTE_W-1:0] lane;

    always_comb begin
        lane = rd[{offset, 3'b000} +: BYTE_W];
        if (byte_mode) begin
            result = {{(32 - BYTE_W){sext & lane[BYTE_W-1]}}, lane};
        end else begin
            result = rd;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one memory request at a time through
// IDLE -> ACCESS -> RESP and returns a response per request.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_*                 : request handshake and fields (we, byte, sext, addr, wdata)
//   resp_*                : response handshake, load data, misalignment flag
//   mem_we/mem_a/mem_wd/mem_b : registered data-memory controls
//   mem_rd                : combinational word-aligned read data
// Optional feature: define LSU_ALIGN_CHECK_EN to flag misaligned word
// accesses (no write, zero data, resp_err=1). Undefined: resp_err is 0.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_sext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_b,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state;
    logic        lat_we;
    logic        lat_sext;
    logic        lat_err;
    logic        req_misaligned;
    logic [31:0] aligned;

`ifdef LSU_ALIGN_CHECK_EN
    assign req_misaligned = !req_byte && (req_addr[1:0] != 2'b00);
`else
    assign req_misaligned = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    // mem_a / mem_b double as the latched address and byte flag.
    load_align u_load_align (
        .rd        (mem_rd),
        .offset    (mem_a[1:0]),
        .byte_mode (mem_b),
        .sext      (lat_sext),
        .result    (aligned)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_sext   <= 1'b0;
            lat_err    <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
            mem_b      <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_sext <= req_sext;
                        lat_err  <= req_misaligned;
                        mem_a    <= req_addr;
                        mem_b    <= req_byte;
                        mem_wd   <= req_byte ? replicate_byte(req_wdata[BYTE_W-1:0]) : req_wdata;
                        // Write enable is registered here so it is high for exactly the ACCESS cycle.
                        mem_we   <= req_we && !req_misaligned;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= (lat_we || lat_err) ? '0 : aligned;
                    resp_err   <= lat_err;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a small word-addressed
// memory model. Table-driven requests plus hand-written sequences for
// byte-store lanes, latency, response back-pressure, reset during an
// access and (with LSU_ALIGN_CHECK_EN) misaligned word accesses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_byte, req_sext;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we, mem_b;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];
    int          pulses = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        we;
        logic        bm;
        logic        sx;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;
    vec_t vecs[15];

    load_store_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_byte   (req_byte),
        .req_sext   (req_sext),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_b      (mem_b),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            pulses <= pulses + 1;
            if (mem_b)
                mem[mem_a[7:2]][{mem_a[1:0], 3'b000} +: 8] <= mem_wd[{mem_a[1:0], 3'b000} +: 8];
            else
                mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!req_ready && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!req_ready) timeout(name);
    endtask

    task automatic drive(input logic we, input logic bm, input logic sx,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_we    = we;
        req_byte  = bm;
        req_sext  = sx;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            timeout({name, "_queue_empty"});
            return;
        end
        e = exp_q.pop_front();
        check({name, "_rdata"}, resp_rdata, e.rdata);
        check({name, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
    endtask

    task automatic run_req(input string name, input logic we, input logic bm, input logic sx,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic err);
        int   p0;
        int   cnt;
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
        @(negedge clk);
        resp_ready = 1'b1;
        wait_ready(name);
        p0 = pulses;
        drive(we, bm, sx, addr, wdata);
        @(negedge clk);
        req_valid = 1'b0;
        cnt = 0;
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!resp_valid) begin
            timeout(name);
            void'(exp_q.pop_front());
        end else begin
            pop_compare(name);
        end
        check({name, "_pulses"}, pulses - p0, (we && !err) ? 1 : 0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] word30;
        int          p0;
        int          cnt;
        exp_t        e;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hA5000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h13, 32'h0,        32'h000000A5, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h10, 32'h0,        32'h00000000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h12, 32'h0,        32'h000000AD, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h20, 32'hFFFFFF7F, 32'h00000000, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0,        32'h0000007F, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h20, 32'h0,        32'h0000007F, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h24, 32'h01020304, 32'h00000000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h24, 32'h0,        32'h01020304, 1'b0};
`ifdef LSU_ALIGN_CHECK_EN
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h11, 32'h0,        32'h00000000, 1'b1};
`else
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h11, 32'h0,        32'hDEADBEEF, 1'b0};
`endif

        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_sext   = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;

        // Reset state
        #12;
        check("rst_req_ready",  {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata,          32'd0);
        check("rst_mem_we",     {31'b0, mem_we},     32'd0);
        check("rst_mem_a",      mem_a,               32'd0);
        check("rst_mem_wd",     mem_wd,              32'd0);
        check("rst_mem_b",      {31'b0, mem_b},      32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Byte store 0xA5 to 0x13: lane replication, byte mode and latency
        e.rdata = 32'h0;
        e.err   = 1'b0;
        exp_q.push_back(e);
        p0 = pulses;
        drive(1'b1, 1'b1, 1'b0, 32'h13, 32'h123456A5);
        @(negedge clk);
        req_valid = 1'b0;
        check("bst_mem_we",     {31'b0, mem_we},     32'd1);
        check("bst_mem_wd",     mem_wd,              32'hA5A5A5A5);
        check("bst_mem_b",      {31'b0, mem_b},      32'd1);
        check("bst_mem_a",      mem_a,               32'h13);
        check("bst_req_ready",  {31'b0, req_ready},  32'd0);
        check("bst_early_resp", {31'b0, resp_valid}, 32'd0);
        @(negedge clk);
        check("bst_resp_valid", {31'b0, resp_valid}, 32'd1);
        check("bst_we_dropped", {31'b0, mem_we},     32'd0);
        pop_compare("bst");
        check("bst_pulses", pulses - p0, 1);
        @(negedge clk);
        check("bst_idle", {31'b0, req_ready}, 32'd1);

        // Table-driven requests
        foreach (vecs[i]) begin
            run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].bm, vecs[i].sx,
                    vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
        end

        // Response back-pressure with a pending second request
        e.rdata = 32'h0;
        e.err   = 1'b0;
        exp_q.push_back(e);
        resp_ready = 1'b0;
        p0 = pulses;
        drive(1'b1, 1'b0, 1'b0, 32'h28, 32'h55AA55AA);
        cnt = 0;
        while (!resp_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!resp_valid) timeout("bp_wait");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), {31'b0, resp_valid}, 32'd1);
            check($sformatf("bp_rdata%0d", i), resp_rdata,          32'd0);
            check($sformatf("bp_ready%0d", i), {31'b0, req_ready},  32'd0);
            @(negedge clk);
        end
        check("bp_pulses", pulses - p0, 1);
        pop_compare("bp");
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        run_req("bp_readback", 1'b0, 1'b0, 1'b0, 32'h28, 32'h0, 32'h55AA55AA, 1'b0);

        // Reset asserted during the ACCESS cycle of a store
        run_req("rs_prefill", 1'b1, 1'b0, 1'b0, 32'h30, 32'h11111111, 32'h0, 1'b0);
        word30 = mem[12];
        check("rs_prefill_mem", word30, 32'h11111111);
        p0 = pulses;
        drive(1'b1, 1'b0, 1'b0, 32'h30, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("rs_access_we", {31'b0, mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rs_mem_we",     {31'b0, mem_we},     32'd0);
        check("rs_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rs_mem_a",      mem_a,               32'd0);
        check("rs_mem_wd",     mem_wd,              32'd0);
        check("rs_mem_b",      {31'b0, mem_b},      32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rs_mem_word", mem[12], 32'h11111111);
        check("rs_pulses", pulses - p0, 0);
        check("rs_req_ready", {31'b0, req_ready}, 32'd1);

`ifdef LSU_ALIGN_CHECK_EN
        // Misaligned word store is suppressed and flagged
        run_req("mis_store", 1'b1, 1'b0, 1'b0, 32'h02, 32'h87654321, 32'h0, 1'b1);
        check("mis_mem_word", mem[0], 32'h0);
        run_req("mis_byte_ok", 1'b1, 1'b1, 1'b0, 32'h02, 32'h00000077, 32'h0, 1'b0);
        check("mis_byte_mem", mem[0], 32'h00770000);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
